tdm_demux_sequencer: RTL and testbench

- Time-division sequencer that sits directly upstream of the 1-to-4 demultiplexer and drives its data bit and 2-bit select.
- Walks the enabled channels round-robin and holds each channel for DWELL cycles.
- Registers the serial input so each data bit is aligned with the select it is routed under.
- Runs a fixed number of frames or runs continuously until stopped, with start/busy/done handshake.

---
 rtl/tdm_demux_pkg.sv | 30 +++
 rtl/rr_next_ch.sv | 37 +++
 rtl/tdm_demux_sequencer.sv | 177 +++++++++++++++++
 tb/tb_tdm_demux_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM demux sequencer.
package tdm_demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the lowest enabled channel; 0 when the mask is empty.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] idx;
    if (mask[0]) begin
      idx = 2'd0;
    end else if (mask[1]) begin
      idx = 2'd1;
    end else if (mask[2]) begin
      idx = 2'd2;
    end else if (mask[3]) begin
      idx = 2'd3;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin channel picker: next enabled channel strictly after cur,
// wrapping 3 -> 0. A single-bit mask returns cur itself (a full lap).
module rr_next_ch
  import tdm_demux_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next,
  output logic              wrap
);

  logic [SEL_W-1:0] idx_s;
  logic             found_s;

  // Scan cur+1 .. cur+4 (mod 4) and keep the first enabled channel.
  always_comb begin
    next    = cur;
    found_s = 1'b0;
    idx_s   = cur;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx_s = cur + SEL_W'(i);
      if (!found_s && mask[idx_s]) begin
        next    = idx_s;
        found_s = 1'b1;
      end else begin
        next    = next;
        found_s = found_s;
      end
    end
  end

  // A move to an index not above the current one closes a frame.
  always_comb begin
    wrap = (next <= cur);
  end

endmodule

// File: rtl/tdm_demux_sequencer.sv
// Time-division sequencer driving the data bit and select of a 1-to-4 demux.
// Visits enabled channels round-robin, DWELL cycles each, for a counted
// number of frames or until stopped at a frame boundary.
module tdm_demux_sequencer #(
  parameter int DWELL       = 4,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  input  logic [3:0]             ch_mask,
  input  logic                   din,
  output logic                   dout,
  output logic [1:0]             sel,
  output logic                   slot_valid,
  output logic                   frame_start,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  import tdm_demux_pkg::*;

  // Dwell counter needs at least one bit even when DWELL is 1.
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  state_t                 state_r, state_n;
  logic [NUM_CH-1:0]      mask_r, mask_n;
  logic [FRAME_CNT_W-1:0] nf_r, nf_n;
  logic                   stop_r, stop_n;
  logic [DW_W-1:0]        dwell_r, dwell_n;
  logic [FRAME_CNT_W-1:0] frame_cnt_r, frame_cnt_n;
  logic [SEL_W-1:0]       sel_r, sel_n;
  logic                   dout_r, dout_n;
  logic                   slot_valid_r, slot_valid_n;
  logic                   frame_start_r, frame_start_n;
  logic                   busy_r, busy_n;
  logic                   done_r, done_n;

  logic [SEL_W-1:0]       nxt_s;
  logic                   wrap_s;
  logic                   advance_s;
  logic                   frame_end_s;
  logic [FRAME_CNT_W-1:0] fc_inc_s;
  logic                   run_end_s;

  rr_next_ch u_rr_next_ch (
    .mask (mask_r),
    .cur  (sel_r),
    .next (nxt_s),
    .wrap (wrap_s)
  );

  // Slot and frame boundary decode for the current RUN cycle.
  always_comb begin
    advance_s   = (dwell_r == DWELL_LAST);
    frame_end_s = advance_s && wrap_s;
    fc_inc_s    = frame_cnt_r + FRAME_CNT_W'(1);
    // A pending or same-cycle stop ends the run only at a frame boundary.
    run_end_s   = frame_end_s &&
                  (((nf_r != {FRAME_CNT_W{1'b0}}) && (fc_inc_s == nf_r)) ||
                   stop_r || stop);
  end

  // Next-state and next-output logic; outputs default to their idle values.
  always_comb begin
    state_n       = state_r;
    mask_n        = mask_r;
    nf_n          = nf_r;
    stop_n        = stop_r;
    dwell_n       = dwell_r;
    frame_cnt_n   = frame_cnt_r;
    sel_n         = sel_r;
    dout_n        = 1'b0;
    slot_valid_n  = 1'b0;
    frame_start_n = 1'b0;
    busy_n        = 1'b0;
    done_n        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && (ch_mask != 4'b0000)) begin
          state_n       = RUN;
          mask_n        = ch_mask;
          nf_n          = num_frames;
          stop_n        = 1'b0;
          dwell_n       = {DW_W{1'b0}};
          frame_cnt_n   = {FRAME_CNT_W{1'b0}};
          sel_n         = lowest_set(ch_mask);
          dout_n        = din;
          slot_valid_n  = 1'b1;
          frame_start_n = 1'b1;
          busy_n        = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          stop_n = 1'b1;
        end else begin
          stop_n = stop_r;
        end
        if (run_end_s) begin
          state_n     = DONE;
          done_n      = 1'b1;
          frame_cnt_n = fc_inc_s;
        end else begin
          state_n      = RUN;
          dout_n       = din;
          slot_valid_n = 1'b1;
          busy_n       = 1'b1;
          if (advance_s) begin
            sel_n   = nxt_s;
            dwell_n = {DW_W{1'b0}};
          end else begin
            dwell_n = dwell_r + DW_W'(1);
          end
          if (frame_end_s) begin
            frame_cnt_n   = fc_inc_s;
            frame_start_n = 1'b1;
          end else begin
            frame_cnt_n = frame_cnt_r;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, control and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      mask_r        <= 4'b0000;
      nf_r          <= {FRAME_CNT_W{1'b0}};
      stop_r        <= 1'b0;
      dwell_r       <= {DW_W{1'b0}};
      frame_cnt_r   <= {FRAME_CNT_W{1'b0}};
      sel_r         <= {SEL_W{1'b0}};
      dout_r        <= 1'b0;
      slot_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_n;
      mask_r        <= mask_n;
      nf_r          <= nf_n;
      stop_r        <= stop_n;
      dwell_r       <= dwell_n;
      frame_cnt_r   <= frame_cnt_n;
      sel_r         <= sel_n;
      dout_r        <= dout_n;
      slot_valid_r  <= slot_valid_n;
      frame_start_r <= frame_start_n;
      busy_r        <= busy_n;
      done_r        <= done_n;
    end
  end

  assign dout        = dout_r;
  assign sel         = sel_r;
  assign slot_valid  = slot_valid_r;
  assign frame_start = frame_start_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_tdm_demux_sequencer.sv
// Directed bench for tdm_demux_sequencer with DWELL=2.
module tb_tdm_demux_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [7:0] num_frames;
  logic [3:0] ch_mask;
  logic       din;
  logic       dout;
  logic [1:0] sel;
  logic       slot_valid;
  logic       frame_start;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  tdm_demux_sequencer #(
    .DWELL       (2),
    .FRAME_CNT_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .num_frames  (num_frames),
    .ch_mask     (ch_mask),
    .din         (din),
    .dout        (dout),
    .sel         (sel),
    .slot_valid  (slot_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done),
    .frame_cnt   (frame_cnt)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive a one-cycle start and land #1 after the accepting edge.
  task automatic do_start(input logic [3:0] mask, input logic [7:0] nf);
    ch_mask    = mask;
    num_frames = nf;
    din        = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  // Check n slot cycles (sel/frame_start/dout per cycle), then the DONE cycle.
  task automatic expect_run(input int n, input logic [63:0] sp, input logic [31:0] fp,
                            input logic [31:0] dp, input int stop_at, input logic [7:0] exp_fc);
    logic exp_dout;
    exp_dout = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("sel[%0d]", i), {30'd0, sel}, {30'd0, sp[2*i +: 2]});
      chk($sformatf("slot_valid[%0d]", i), {31'd0, slot_valid}, 32'd1);
      chk($sformatf("busy[%0d]", i), {31'd0, busy}, 32'd1);
      chk($sformatf("frame_start[%0d]", i), {31'd0, frame_start}, {31'd0, fp[i]});
      chk($sformatf("done_low[%0d]", i), {31'd0, done}, 32'd0);
      chk($sformatf("dout[%0d]", i), {31'd0, dout}, {31'd0, exp_dout});
      din      = dp[i];
      stop     = (i == stop_at);
      exp_dout = dp[i];
      @(posedge clk); #1;
    end
    din  = 1'b0;
    stop = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_slot_valid", {31'd0, slot_valid}, 32'd0);
    chk("done_dout", {31'd0, dout}, 32'd0);
    chk("done_frame_start", {31'd0, frame_start}, 32'd0);
    chk("done_frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_fc});
  endtask

  // One cycle after DONE: back in IDLE with quiet outputs.
  task automatic idle_check(input logic [7:0] exp_fc);
    @(posedge clk); #1;
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_slot_valid", {31'd0, slot_valid}, 32'd0);
    chk("idle_dout", {31'd0, dout}, 32'd0);
    chk("idle_frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_fc});
  endtask

  // Directed sequence.
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    num_frames = 8'd0;
    ch_mask    = 4'b0000;
    din        = 1'b0;
    #1;
    chk("rst_dout", {31'd0, dout}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_slot_valid", {31'd0, slot_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // All four channels, one frame, din pattern 1,0,1,1,0.
    do_start(4'b1111, 8'd1);
    expect_run(8, 64'h0000_0000_0000_FA50, 32'h0000_0001, 32'h0000_000D, -1, 8'd1);
    idle_check(8'd1);

    // Channels 1 and 3, two frames.
    do_start(4'b1010, 8'd2);
    expect_run(8, 64'h0000_0000_0000_F5F5, 32'h0000_0011, 32'h0000_00A5, -1, 8'd2);
    idle_check(8'd2);

    // Single channel 2, three frames; start in DONE is ignored.
    do_start(4'b0100, 8'd3);
    expect_run(6, 64'h0000_0000_0000_0AAA, 32'h0000_0015, 32'h0000_0036, -1, 8'd3);
    ch_mask = 4'b1111;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    chk("done_start_busy", {31'd0, busy}, 32'd0);
    chk("done_start_slot_valid", {31'd0, slot_valid}, 32'd0);
    chk("done_start_frame_cnt", {24'd0, frame_cnt}, 32'd3);
    idle_check(8'd3);

    // Continuous run stopped in frame 3's sel=1 slot; mask/nf changes ignored.
    do_start(4'b1111, 8'd0);
    ch_mask    = 4'b0001;
    num_frames = 8'd1;
    expect_run(24, 64'h0000_FA50_FA50_FA50, 32'h0001_0101, 32'h00C3_5A69, 18, 8'd3);
    idle_check(8'd3);

    // Stop on the same edge as the final counted frame: one done only.
    do_start(4'b0001, 8'd1);
    expect_run(2, 64'h0000_0000_0000_0000, 32'h0000_0001, 32'h0000_0002, 1, 8'd1);
    idle_check(8'd1);

    // Reset mid-run clears outputs without a clock edge.
    do_start(4'b1111, 8'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dout", {31'd0, dout}, 32'd0);
    chk("midrst_sel", {30'd0, sel}, 32'd0);
    chk("midrst_slot_valid", {31'd0, slot_valid}, 32'd0);
    chk("midrst_frame_start", {31'd0, frame_start}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Start with an empty mask is ignored.
    do_start(4'b0000, 8'd2);
    chk("empty_busy", {31'd0, busy}, 32'd0);
    chk("empty_slot_valid", {31'd0, slot_valid}, 32'd0);
    chk("empty_frame_start", {31'd0, frame_start}, 32'd0);
    chk("empty_done", {31'd0, done}, 32'd0);
    idle_check(8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
